cond_unit: RTL and testbench
============================

Name: cond_unit

Overview:
- Execute-stage conditional-execution unit for the pipelined ARM-subset core.
- Holds the architectural NZCV flags register and evaluates each instruction's 4-bit condition field against the current flags.
- Gates the instruction's write/branch controls and registers the gated controls into the E/M pipeline boundary.
- Feeds the memory/writeback stages. Sits directly downstream of the decoder and ALU.

Parameters:
- CNT_W, 16, width of the optional statistics counters (used only with COND_STATS_EN).

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- stall_i  input  1  hold E stage: no state change
- flush_i  input  1  squash the instruction currently in E
- valid_i  input  1  E stage holds a real instruction
- cond_i  input  4  instruction condition field
- alu_flags_i  input  4  {N,Z,C,V} produced by the ALU this cycle
- flag_write_i  input  2  bit1: update N,Z; bit0: update C,V
- pc_src_i  input  1  instruction writes PC/branches
- reg_write_i  input  1  instruction writes register file
- mem_write_i  input  1  instruction writes memory
- no_write_i  input  1  compare-class instruction; suppress reg write
- cond_ex_o  output  1  combinational condition result for the current E instruction
- flags_o  output  4  registered NZCV
- valid_o  output  1  registered: M-stage instruction valid
- pc_src_o  output  1  registered gated branch control
- reg_write_o  output  1  registered gated register write
- mem_write_o  output  1  registered gated memory write
- illegal_cond_o  output  1  sticky: a cond of 4'b1111 reached E

Behaviour:
- Reset is synchronous and active-low: on a rising edge with reset_n=0, every registered output and flags_o go to 0. This includes illegal_cond_o and the counters. Reset overrides stall_i and flush_i.
- cond_ex_o is combinational from cond_i and the registered flags (not alu_flags_i):
  - 0000 EQ=Z, 0001 NE=!Z, 0010 CS=C, 0011 CC=!C
  - 0100 MI=N, 0101 PL=!N, 0110 VS=V, 0111 VC=!V
  - 1000 HI=C&!Z, 1001 LS=!C|Z, 1010 GE=N==V, 1011 LT=N!=V
  - 1100 GT=!Z&(N==V), 1101 LE=Z|(N!=V), 1110 AL=1
  - 1111 = 0; never X.
- Define go = valid_i & cond_ex_o & !flush_i & !stall_i.
- Flag update at the clock edge when go:
  - N,Z <= alu_flags_i[3:2] if flag_write_i[1].
  - C,V <= alu_flags_i[1:0] if flag_write_i[0].
  - Each half updates independently.
- Output register, one-cycle latency E->M:
  - valid_o <= valid_i & !flush_i
  - pc_src_o <= pc_src_i & go
  - reg_write_o <= reg_write_i & !no_write_i & go
  - mem_write_o <= mem_write_i & go
- stall_i=1 with flush_i=0: all registers, including flags, hold their values.
- flush_i=1: output controls and valid_o clear to 0 and no flag update, regardless of stall_i. Flush wins over stall.
- Failed condition: the instruction still propagates with valid_o=1 and all gated controls 0.
- illegal_cond_o sets when valid_i & !flush_i & !stall_i & cond_i==4'b1111. It clears only on reset.
- Back-to-back flag setters: the second instruction's cond_ex_o sees the first's flags in the cycle after the first's E cycle. There is no same-cycle bypass.

Optional Feature:
- Macro: COND_STATS_EN.
- Defined:
  - Adds outputs exec_cnt_o[CNT_W] and squash_cnt_o[CNT_W].
  - exec_cnt_o increments on go.
  - squash_cnt_o increments when valid_i & !cond_ex_o & !flush_i & !stall_i.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: no counters and no extra ports. All other behaviour is identical.

Decomposition:
- Shared package cond_pkg holds:
  - cond_e enum for the 16 condition codes.
  - Flag bit-index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - flag_write field constants FW_NZ=2'b10, FW_CV=2'b01.
- One combinational sub-module, cond_eval (cond, flags -> cond_ex), holds the decode table. cond_unit instantiates it and owns all state.

Test Plan:
- Reset: reset_n=0 for 2 cycles with valid_i=1, cond=1110, flag_write=11, alu_flags=1111 -> flags_o=0000, all outputs 0, illegal_cond_o=0.
- CMP then BEQ: cycle0 cond=1110, flag_write=11, alu_flags=0100, no_write=1, reg_write=1; cycle1 cond=0000, pc_src=1:
  - flags_o=0100 after cycle0
  - cycle1 cond_ex_o=1
  - pc_src_o=1 in cycle2
  - reg_write_o=0 in cycle1
- Partial flag write: flags=1111, flag_write=10, alu_flags=0000, AL -> flags_o=0011.
- Failed condition: flags Z=0, cond=0000, reg_write=1, mem_write=1, flag_write=11 -> valid_o=1, reg_write_o=0, mem_write_o=0, flags unchanged.
- Stall/flush: stall_i=1 with an AL flag-setter -> flags and outputs held. stall_i=1 & flush_i=1 -> valid_o=0, controls 0, flags unchanged.
- Illegal code and stats: cond=1111, valid=1 -> cond_ex_o=0, illegal_cond_o=1 and sticky. With COND_STATS_EN and CNT_W=2, 5 executed AL instructions -> exec_cnt_o=3 (saturated).

Source files
------------

// File: rtl/cond_pkg.sv
// cond_pkg: condition codes, flag bit positions and flag-write field constants
package cond_pkg;
  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam logic [1:0] FW_NZ = 2'b10;
  localparam logic [1:0] FW_CV = 2'b01;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: decodes a 4-bit condition field against NZCV; the reserved code never executes
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);
  logic n, z, c, v;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];
  // condition decode table
  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(cond))
      EQ: cond_ex = z;
      NE: cond_ex = !z;
      CS: cond_ex = c;
      CC: cond_ex = !c;
      MI: cond_ex = n;
      PL: cond_ex = !n;
      VS: cond_ex = v;
      VC: cond_ex = !v;
      HI: cond_ex = c & !z;
      LS: cond_ex = !c | z;
      GE: cond_ex = n == v;
      LT: cond_ex = n != v;
      GT: cond_ex = !z & (n == v);
      LE: cond_ex = z | (n != v);
      AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
endmodule

// File: rtl/cond_unit.sv
// cond_unit: NZCV flag register, condition gating of E-stage controls and the E/M register.
// Defining COND_STATS_EN adds saturating executed/squashed instruction counters.
module cond_unit
  import cond_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [3:0]       cond_i,
  input  logic [3:0]       alu_flags_i,
  input  logic [1:0]       flag_write_i,
  input  logic             pc_src_i,
  input  logic             reg_write_i,
  input  logic             mem_write_i,
  input  logic             no_write_i,
  output logic             cond_ex_o,
  output logic [3:0]       flags_o,
  output logic             valid_o,
  output logic             pc_src_o,
  output logic             reg_write_o,
  output logic             mem_write_o,
`ifdef COND_STATS_EN
  output logic [CNT_W-1:0] exec_cnt_o,
  output logic [CNT_W-1:0] squash_cnt_o,
`endif
  output logic             illegal_cond_o
);
  logic adv, go;
  cond_eval u_eval (.cond(cond_i), .flags(flags_o), .cond_ex(cond_ex_o));
  assign adv = valid_i & !flush_i & !stall_i;
  assign go  = adv & cond_ex_o;
  // flags, E/M boundary and sticky illegal flag; flush beats stall, reset beats both
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flags_o        <= '0;
      valid_o        <= 1'b0;
      pc_src_o       <= 1'b0;
      reg_write_o    <= 1'b0;
      mem_write_o    <= 1'b0;
      illegal_cond_o <= 1'b0;
    end else if (flush_i) begin
      valid_o     <= 1'b0;
      pc_src_o    <= 1'b0;
      reg_write_o <= 1'b0;
      mem_write_o <= 1'b0;
    end else if (!stall_i) begin
      valid_o     <= valid_i;
      pc_src_o    <= pc_src_i & go;
      reg_write_o <= reg_write_i & !no_write_i & go;
      mem_write_o <= mem_write_i & go;
      if (go && (flag_write_i & FW_NZ) != 2'b00) flags_o[3:2] <= alu_flags_i[3:2];
      if (go && (flag_write_i & FW_CV) != 2'b00) flags_o[1:0] <= alu_flags_i[1:0];
      if (adv && cond_e'(cond_i) == NV) illegal_cond_o <= 1'b1;
    end
  end
`ifdef COND_STATS_EN
  // saturating executed / condition-failed counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      exec_cnt_o   <= '0;
      squash_cnt_o <= '0;
    end else begin
      if (go && !(&exec_cnt_o)) exec_cnt_o <= exec_cnt_o + 1'b1;
      if (adv && !cond_ex_o && !(&squash_cnt_o)) squash_cnt_o <= squash_cnt_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed and random checks of cond_unit against a behavioural model
module tb_cond_unit;
`ifdef COND_STATS_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0, stall_i = 1'b0, flush_i = 1'b0, valid_i = 1'b0;
  logic [3:0] cond_i = '0, alu_flags_i = '0;
  logic [1:0] flag_write_i = '0;
  logic pc_src_i = 1'b0, reg_write_i = 1'b0, mem_write_i = 1'b0, no_write_i = 1'b0;
  logic cond_ex_o, valid_o, pc_src_o, reg_write_o, mem_write_o, illegal_cond_o;
  logic [3:0] flags_o;
`ifdef COND_STATS_EN
  logic [CW-1:0] exec_cnt_o, squash_cnt_o;
`endif
  int total = 0, bad = 0;
  logic [3:0] m_flags = '0;
  logic m_valid = 0, m_pc = 0, m_rw = 0, m_mw = 0, m_ill = 0;
  int m_exec = 0, m_squash = 0;
  localparam int SAT = (1 << CW) - 1;

  cond_unit #(.CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .cond_i(cond_i), .alu_flags_i(alu_flags_i), .flag_write_i(flag_write_i),
    .pc_src_i(pc_src_i), .reg_write_i(reg_write_i), .mem_write_i(mem_write_i),
    .no_write_i(no_write_i), .cond_ex_o(cond_ex_o), .flags_o(flags_o), .valid_o(valid_o),
    .pc_src_o(pc_src_o), .reg_write_o(reg_write_o), .mem_write_o(mem_write_o),
`ifdef COND_STATS_EN
    .exec_cnt_o(exec_cnt_o), .squash_cnt_o(squash_cnt_o),
`endif
    .illegal_cond_o(illegal_cond_o)
  );

  always #5 clk = ~clk;

  // ARM style: pairs of codes share a base test, odd codes invert it; 1111 never runs
  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = n == v;
      3'd6: base = !z && n == v;
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                       input logic pc, input logic rw, input logic mw, input logic nw);
    valid_i = v; cond_i = c; flag_write_i = fw; alu_flags_i = af;
    pc_src_i = pc; reg_write_i = rw; mem_write_i = mw; no_write_i = nw;
  endtask

  task automatic step();
    logic ce, go, run;
    #1;
    ce = cond_ref(cond_i, m_flags);
    chk("cond_ex", {15'd0, cond_ex_o}, {15'd0, ce});
    run = valid_i && !flush_i && !stall_i;
    go = run && ce;
    if (!reset_n) begin
      m_flags = 0; m_valid = 0; m_pc = 0; m_rw = 0; m_mw = 0; m_ill = 0; m_exec = 0; m_squash = 0;
    end else begin
      if (go && m_exec < SAT) m_exec++;
      if (run && !ce && m_squash < SAT) m_squash++;
      if (flush_i) begin
        m_valid = 0; m_pc = 0; m_rw = 0; m_mw = 0;
      end else if (!stall_i) begin
        m_valid = valid_i;
        m_pc = pc_src_i && go;
        m_rw = reg_write_i && !no_write_i && go;
        m_mw = mem_write_i && go;
        if (go && flag_write_i[1]) m_flags[3:2] = alu_flags_i[3:2];
        if (go && flag_write_i[0]) m_flags[1:0] = alu_flags_i[1:0];
        if (run && cond_i == 4'hF) m_ill = 1;
      end
    end
    @(posedge clk);
    #1;
    chk("flags", {12'd0, flags_o}, {12'd0, m_flags});
    chk("valid", {15'd0, valid_o}, {15'd0, m_valid});
    chk("pc_src", {15'd0, pc_src_o}, {15'd0, m_pc});
    chk("reg_write", {15'd0, reg_write_o}, {15'd0, m_rw});
    chk("mem_write", {15'd0, mem_write_o}, {15'd0, m_mw});
    chk("illegal", {15'd0, illegal_cond_o}, {15'd0, m_ill});
`ifdef COND_STATS_EN
    chk("exec_cnt", 16'(exec_cnt_o), 16'(m_exec));
    chk("squash_cnt", 16'(squash_cnt_o), 16'(m_squash));
`endif
  endtask

  initial begin
    @(posedge clk);
    #1;
    // reset dominates a live flag setter
    reset_n = 0;
    drive(1, 4'hE, 2'b11, 4'hF, 1, 1, 1, 0);
    step(); step();
    chk("rst_flags", {12'd0, flags_o}, 16'h0);
    chk("rst_valid", {15'd0, valid_o}, 16'h0);
    chk("rst_ill", {15'd0, illegal_cond_o}, 16'h0);
    reset_n = 1;
    // CMP then BEQ
    drive(1, 4'hE, 2'b11, 4'h4, 0, 1, 0, 1);
    step();
    chk("cmp_flags", {12'd0, flags_o}, 16'h4);
    chk("cmp_rw", {15'd0, reg_write_o}, 16'h0);
    drive(1, 4'h0, 2'b00, 4'h0, 1, 0, 0, 0);
    #1 chk("beq_cond", {15'd0, cond_ex_o}, 16'h1);
    step();
    chk("beq_pc", {15'd0, pc_src_o}, 16'h1);
    // partial flag write
    drive(1, 4'hE, 2'b11, 4'hF, 0, 0, 0, 0);
    step();
    drive(1, 4'hE, 2'b10, 4'h0, 0, 0, 0, 0);
    step();
    chk("partial", {12'd0, flags_o}, 16'h3);
    // failed EQ with Z=0
    drive(1, 4'h0, 2'b11, 4'h4, 0, 1, 1, 0);
    step();
    chk("fail_valid", {15'd0, valid_o}, 16'h1);
    chk("fail_rw", {15'd0, reg_write_o}, 16'h0);
    chk("fail_mw", {15'd0, mem_write_o}, 16'h0);
    chk("fail_flags", {12'd0, flags_o}, 16'h3);
    // stall holds, stall+flush clears
    stall_i = 1;
    drive(1, 4'hE, 2'b11, 4'hC, 1, 1, 1, 0);
    step();
    chk("stall_flags", {12'd0, flags_o}, 16'h3);
    chk("stall_valid", {15'd0, valid_o}, 16'h1);
    flush_i = 1;
    step();
    chk("flush_valid", {15'd0, valid_o}, 16'h0);
    chk("flush_pc", {15'd0, pc_src_o}, 16'h0);
    chk("flush_flags", {12'd0, flags_o}, 16'h3);
    stall_i = 0; flush_i = 0;
    // illegal condition is sticky
    drive(1, 4'hF, 2'b11, 4'h0, 1, 1, 1, 0);
    #1 chk("nv_cond", {15'd0, cond_ex_o}, 16'h0);
    step();
    chk("ill_set", {15'd0, illegal_cond_o}, 16'h1);
    drive(1, 4'hE, 2'b00, 4'h0, 0, 0, 0, 0);
    step(); step();
    chk("ill_sticky", {15'd0, illegal_cond_o}, 16'h1);
`ifdef COND_STATS_EN
    reset_n = 0;
    step();
    reset_n = 1;
    for (int i = 0; i < 5; i++) step();
    chk("exec_sat", 16'(exec_cnt_o), 16'd3);
`endif
    // random traffic
    for (int i = 0; i < 600; i++) begin
      reset_n = ($urandom_range(0, 63) != 0);
      stall_i = ($urandom_range(0, 7) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
      drive(1'($urandom), 4'($urandom), 2'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
